pr_hrav_icap_word_feeder: RTL

Downstream stage of the ICAP controller's bitstream path. Accepts 256-bit AXI4-Stream beats carrying partial-bitstream payload and serialises them into 32-bit words on the ICAP write port. The feeder drops lanes by TSTRB, applies the Xilinx per-byte bit swap, and reports per-packet word counts. It sits between the controller's internal payload stream and the ICAPE2 primitive, in the ACLK domain.

---
 rtl/pr_hrav_icap_word_feeder_pkg.sv | 30 +++
 rtl/pr_hrav_icap_word_feeder_if.sv | 26 ++
 rtl/pr_hrav_lane_pick.sv | 27 ++
 rtl/pr_hrav_icap_word_feeder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pr_hrav_icap_word_feeder_pkg.sv
// Shared types, sizes and helpers for the ICAP word feeder.
package pr_hrav_icap_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } feeder_state_e;

  // Reverse bit order inside each byte (Xilinx ICAP bit ordering).
  function automatic logic [LANE_W-1:0] bitswap32(input logic [LANE_W-1:0] w);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*b+j] = w[8*b+7-j];
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pr_hrav_icap_word_feeder_if.sv
// AXI4-Stream payload interface feeding the ICAP word feeder.
interface pr_hrav_icap_word_feeder_if #(
  parameter int unsigned DataWidth = 256
);
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tstrb;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata,
    output tstrb,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/pr_hrav_lane_pick.sv
// Priority encoder: lowest set lane of the mask plus an "only bit left" flag.
module pr_hrav_lane_pick
  import pr_hrav_icap_pkg::*;
(
  input  logic [LANES-1:0]      mask_i,
  output logic [LANE_IDX_W-1:0] idx_o,
  output logic                  any_o,
  output logic                  last_o
);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        idx_o = k[LANE_IDX_W-1:0];
      end
    end
  end

  // Last when exactly one bit remains set.
  always_comb begin
    any_o  = |mask_i;
    last_o = any_o && ((mask_i & (mask_i - 1'b1)) == '0);
  end

endmodule

// File: rtl/pr_hrav_icap_word_feeder.sv
// Serialises 256-bit AXI4-Stream beats into 32-bit ICAP write words.
module pr_hrav_icap_word_feeder
  import pr_hrav_icap_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
  parameter bit          C_BIT_SWAP          = 1'b1
) (
  input  logic                       ACLK,
  input  logic                       RESETN,
  input  logic                       feeder_enb,
  pr_hrav_icap_word_feeder_if.slave  s_axis,
  output logic                       icap_csib,
  output logic                       icap_rdwrb,
  output logic [LANE_W-1:0]          icap_i,
  output logic                       pkt_done,
  output logic [CNT_W-1:0]           last_pkt_words,
  output logic                       strb_err
);

  feeder_state_e                  state_q, state_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]               mask_q, mask_d;
  logic                           tlast_q, tlast_d;
  logic                           rst_done_q;
  logic                           csib_q, csib_d;
  logic                           rdwrb_q;
  logic [LANE_W-1:0]              icap_q, icap_d;
  logic                           pkt_done_q, pkt_done_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]               last_q, last_d;
  logic                           strb_err_q, strb_err_d;

  logic [LANES-1:0]      in_mask;
  logic                  in_partial;
  logic [LANE_IDX_W-1:0] pick_idx;
  logic                  pick_any;
  logic                  pick_last;
  logic [LANE_W-1:0]     lane_word;
  logic [CNT_W-1:0]      word_cnt;
  logic                  tready;

  // Classify incoming lane strobes: full lanes emit, partial lanes flag an error.
  always_comb begin
    in_mask    = '0;
    in_partial = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      in_mask[k] = (s_axis.tstrb[4*k +: 4] == 4'hF);
      if ((s_axis.tstrb[4*k +: 4] != 4'h0) && (s_axis.tstrb[4*k +: 4] != 4'hF)) begin
        in_partial = 1'b1;
      end
    end
  end

  pr_hrav_lane_pick u_lane_pick (
    .mask_i (mask_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any),
    .last_o (pick_last)
  );

  // Lane select from the buffered beat.
  always_comb begin
    lane_word = data_q[pick_idx*LANE_W +: LANE_W];
  end

  // Next-state, handshake and output-word logic.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    tlast_d    = tlast_q;
    csib_d     = 1'b1;
    icap_d     = icap_q;
    pkt_done_d = 1'b0;
    cnt_d      = cnt_q;
    last_d     = last_q;
    strb_err_d = strb_err_q;
    word_cnt   = cnt_q;
    tready     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tready = rst_done_q;
      end
      StDrain: begin
        if (feeder_enb) begin
          if (pick_any) begin
            csib_d           = 1'b0;
            icap_d           = C_BIT_SWAP ? bitswap32(lane_word) : lane_word;
            mask_d[pick_idx] = 1'b0;
            word_cnt         = sat_inc(cnt_q);
            cnt_d            = word_cnt;
          end
          // Final lane (or an empty mask) frees the buffer this cycle.
          if (!pick_any || pick_last) begin
            tready  = 1'b1;
            state_d = StIdle;
            if (tlast_q) begin
              last_d     = word_cnt;
              cnt_d      = '0;
              pkt_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A beat accepted here overrides the buffer state above.
    if (tready && s_axis.tvalid) begin
      data_d  = s_axis.tdata;
      mask_d  = in_mask;
      tlast_d = s_axis.tlast;
      state_d = StDrain;
      if (in_partial) begin
        strb_err_d = 1'b1;
      end
    end
  end

  // State and output registers; reset discards any buffered beat and count.
  always_ff @(posedge ACLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      data_q     <= '0;
      mask_q     <= '0;
      tlast_q    <= 1'b0;
      rst_done_q <= 1'b0;
      csib_q     <= 1'b1;
      rdwrb_q    <= 1'b1;
      icap_q     <= '0;
      pkt_done_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= '0;
      strb_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      tlast_q    <= tlast_d;
      rst_done_q <= 1'b1;
      csib_q     <= csib_d;
      rdwrb_q    <= 1'b0;
      icap_q     <= icap_d;
      pkt_done_q <= pkt_done_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      strb_err_q <= strb_err_d;
    end
  end

  // Output wiring.
  always_comb begin
    s_axis.tready  = tready;
    icap_csib      = csib_q;
    icap_rdwrb     = rdwrb_q;
    icap_i         = icap_q;
    pkt_done       = pkt_done_q;
    last_pkt_words = last_q;
    strb_err       = strb_err_q;
  end

endmodule
